apb3_cmd_master: RTL and testbench

- APB3 requester (initiator) for the APB3 CSR slave of the Modbus converter.
- Accepts single register-access commands on a valid/ready interface and runs the APB setup and access phases, including PREADY wait states and a timeout watchdog.
- Returns read data and status on a valid/ready response channel.
- Used by host-side bridges (UART debug monitor, scan sequencer) and by the system testbench to drive converter CSRs.

---
 rtl/apb_pkg.sv | 26 ++
 rtl/apb_watchdog.sv | 40 ++++
 rtl/apb3_cmd_master.sv | 183 ++++++++++++++++++
 tb/tb_apb3_cmd_master.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB3 requester definitions: state encoding, bus widths, response bundle.
// Pure declarations, so it has no latency or backpressure of its own.
package apb_pkg;

  localparam int APB_DATA_W          = 32;
  localparam int APB_STRB_W          = 4;
  localparam int APB_TIMEOUT_CYC_DEF = 256;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/apb_watchdog.sv
// ACCESS-phase wait counter; o_tc pulses combinationally on the last allowed wait cycle.
// Clear wins over enable; TIMEOUT_CYC=0 never fires.
module apb_watchdog
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYC = APB_TIMEOUT_CYC_DEF
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  generate
    if (TIMEOUT_CYC == 0) begin : g_off
      logic w_unused;
      assign w_unused = i_clr ^ i_en;
      assign o_tc     = 1'b0;
    end else begin : g_on
      localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYC - 1);
      logic [CNT_W-1:0] r_cnt;

      always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
          r_cnt <= '0;
        end else if (i_clr) begin
          r_cnt <= '0;
        end else if (i_en) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      assign o_tc = i_en && (r_cnt == TC_VAL);
    end
  endgenerate

endmodule

// File: rtl/apb3_cmd_master.sv
// APB3 requester: one command -> SETUP/ACCESS -> response; rsp_valid 3 cycles after accept plus PREADY waits.
// cmd_ready only in IDLE; response held until rsp_ready, next command accepted the cycle after.
module apb3_cmd_master
  import apb_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int TIMEOUT_CYC = APB_TIMEOUT_CYC_DEF
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [APB_DATA_W-1:0] cmd_wdata,
  input  logic [APB_STRB_W-1:0] cmd_strb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [APB_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic [15:0]           txn_count,
  output logic [15:0]           err_count,
  output logic [ADDR_W-1:0]     PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [APB_DATA_W-1:0] PWDATA,
  output logic [APB_STRB_W-1:0] PSTRB,
  input  logic [APB_DATA_W-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  apb_state_e            r_state, w_state_nxt;
  logic                  r_cmd_ready, r_busy;
  logic [ADDR_W-1:0]     r_paddr, w_paddr_nxt;
  logic                  r_psel, w_psel_nxt;
  logic                  r_penable, w_penable_nxt;
  logic                  r_pwrite, w_pwrite_nxt;
  logic [APB_DATA_W-1:0] r_pwdata, w_pwdata_nxt;
  logic [APB_STRB_W-1:0] r_pstrb, w_pstrb_nxt;
  apb_rsp_t              r_rsp, w_rsp_nxt;
  logic                  r_rsp_valid, w_rsp_valid_nxt;
  logic [15:0]           r_txn_count, w_txn_count_nxt;
  logic [15:0]           r_err_count, w_err_count_nxt;
  logic                  w_wd_clr, w_wd_en, w_wd_tc;
  logic                  w_unused_addr_lsb;

  // Word-aligned APB: the byte offset within the word is dropped.
  assign w_unused_addr_lsb = ^cmd_addr[1:0];

  assign w_wd_clr = (r_state == ST_SETUP);
  assign w_wd_en  = (r_state == ST_ACCESS) && !PREADY;

  apb_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .i_clr  (w_wd_clr),
    .i_en   (w_wd_en),
    .o_tc   (w_wd_tc)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_paddr_nxt      = r_paddr;
    w_psel_nxt       = r_psel;
    w_penable_nxt    = r_penable;
    w_pwrite_nxt     = r_pwrite;
    w_pwdata_nxt     = r_pwdata;
    w_pstrb_nxt      = r_pstrb;
    w_rsp_nxt        = r_rsp;
    w_rsp_valid_nxt  = r_rsp_valid;
    w_txn_count_nxt  = r_txn_count;
    w_err_count_nxt  = r_err_count;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_paddr_nxt   = {cmd_addr[ADDR_W-1:2], 2'b00};
          w_pwrite_nxt  = cmd_write;
          w_pwdata_nxt  = cmd_wdata;
          w_pstrb_nxt   = cmd_write ? cmd_strb : '0;
          w_psel_nxt    = 1'b1;
          w_penable_nxt = 1'b0;
          w_state_nxt   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        w_penable_nxt = 1'b1;
        w_state_nxt   = ST_ACCESS;
      end
      ST_ACCESS: begin
        // A late PREADY on the terminal cycle still completes the transfer normally.
        if (PREADY) begin
          w_rsp_nxt.rdata   = r_pwrite ? '0 : PRDATA;
          w_rsp_nxt.err     = PSLVERR;
          w_rsp_nxt.timeout = 1'b0;
          w_psel_nxt        = 1'b0;
          w_penable_nxt     = 1'b0;
          w_txn_count_nxt   = r_txn_count + 16'd1;
          w_err_count_nxt   = PSLVERR ? sat_inc16(r_err_count) : r_err_count;
          w_rsp_valid_nxt   = 1'b1;
          w_state_nxt       = ST_RESP;
        end else if (w_wd_tc) begin
          w_rsp_nxt.rdata   = '0;
          w_rsp_nxt.err     = 1'b1;
          w_rsp_nxt.timeout = 1'b1;
          w_psel_nxt        = 1'b0;
          w_penable_nxt     = 1'b0;
          w_txn_count_nxt   = r_txn_count + 16'd1;
          w_err_count_nxt   = sat_inc16(r_err_count);
          w_rsp_valid_nxt   = 1'b1;
          w_state_nxt       = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake flags come from the next state so they stay registered yet coherent.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_paddr     <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_pstrb     <= '0;
      r_rsp       <= '0;
      r_rsp_valid <= 1'b0;
      r_txn_count <= '0;
      r_err_count <= '0;
    end else begin
      r_cmd_ready <= (w_state_nxt == ST_IDLE);
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_paddr     <= w_paddr_nxt;
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_pwrite    <= w_pwrite_nxt;
      r_pwdata    <= w_pwdata_nxt;
      r_pstrb     <= w_pstrb_nxt;
      r_rsp       <= w_rsp_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_txn_count <= w_txn_count_nxt;
      r_err_count <= w_err_count_nxt;
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign busy        = r_busy;
  assign PADDR       = r_paddr;
  assign PSEL        = r_psel;
  assign PENABLE     = r_penable;
  assign PWRITE      = r_pwrite;
  assign PWDATA      = r_pwdata;
  assign PSTRB       = r_pstrb;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp.rdata;
  assign rsp_err     = r_rsp.err;
  assign rsp_timeout = r_rsp.timeout;
  assign txn_count   = r_txn_count;
  assign err_count   = r_err_count;

endmodule

// File: tb/tb_apb3_cmd_master.sv
// Directed plus randomized bench for apb3_cmd_master with a transaction-level expectation model.
module tb_apb3_cmd_master;

  localparam int AW = 12;
  localparam int TO = 8;

  logic          PCLK = 1'b0;
  logic          PRESETn = 1'b0;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [31:0]   cmd_wdata = '0;
  logic [3:0]    cmd_strb = '0;
  logic          rsp_valid, rsp_ready = 1'b0;
  logic [31:0]   rsp_rdata;
  logic          rsp_err, rsp_timeout, busy;
  logic [15:0]   txn_count, err_count;
  logic [AW-1:0] PADDR;
  logic          PSEL, PENABLE, PWRITE;
  logic [31:0]   PWDATA;
  logic [3:0]    PSTRB;
  logic [31:0]   PRDATA = '0;
  logic          PREADY = 1'b0, PSLVERR = 1'b0;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] m_txn = '0;
  logic [15:0] m_err = '0;

  apb3_cmd_master #(.ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
    .txn_count(txn_count), .err_count(err_count),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic junk_cmd();
    cmd_valid = 1'($urandom_range(0, 1));
    cmd_write = 1'($urandom_range(0, 1));
    cmd_addr  = AW'($urandom);
    cmd_wdata = $urandom;
    cmd_strb  = 4'($urandom);
  endtask

  // waits < 0 means the slave never answers; hold = cycles rsp_ready stays low.
  task automatic do_txn(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wd,
                        input logic [3:0] st, input int waits, input logic slverr,
                        input logic [31:0] rd, input int hold);
    logic [AW-1:0] e_addr;
    logic [3:0]    e_strb;
    logic          tmo, e_err;
    logic [31:0]   e_rd;
    int            last;
    e_addr = {addr[AW-1:2], 2'b00};
    e_strb = wr ? st : 4'h0;
    tmo    = !(waits >= 0 && waits < TO);
    last   = tmo ? TO - 1 : waits;
    e_err  = tmo || slverr;
    e_rd   = (wr || tmo) ? 32'h0 : rd;

    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_strb = st;
    step();
    junk_cmd();
    chk("setup_psel", 32'(PSEL), 32'd1);
    chk("setup_penable", 32'(PENABLE), 32'd0);
    chk("setup_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("setup_busy", 32'(busy), 32'd1);
    chk("paddr", 32'(PADDR), 32'(e_addr));
    chk("pwrite", 32'(PWRITE), 32'(wr));
    chk("pwdata", PWDATA, wd);
    chk("pstrb", 32'(PSTRB), 32'(e_strb));
    step();
    chk("access_penable", 32'(PENABLE), 32'd1);
    chk("access_psel", 32'(PSEL), 32'd1);
    for (int c = 0; c <= last; c++) begin
      PREADY  = (c == waits);
      PRDATA  = (c == waits) ? rd : $urandom;
      PSLVERR = (c == waits) ? slverr : 1'($urandom_range(0, 1));
      step();
      PREADY = 1'b0; PSLVERR = 1'b0;
      if (c < last) begin
        chk("wait_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("wait_psel", 32'(PSEL), 32'd1);
        chk("wait_penable", 32'(PENABLE), 32'd1);
        chk("wait_paddr", 32'(PADDR), 32'(e_addr));
        chk("wait_pstrb", 32'(PSTRB), 32'(e_strb));
      end
    end
    m_txn = m_txn + 16'd1;
    if (e_err && m_err != 16'hFFFF) m_err = m_err + 16'd1;
    for (int h = 0; h <= hold; h++) begin
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_rdata", rsp_rdata, e_rd);
      chk("rsp_err", 32'(rsp_err), 32'(e_err));
      chk("rsp_timeout", 32'(rsp_timeout), 32'(tmo));
      chk("resp_psel", 32'({PSEL, PENABLE}), 32'd0);
      chk("resp_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("resp_paddr", 32'(PADDR), 32'(e_addr));
      chk("txn_count", 32'(txn_count), 32'(m_txn));
      chk("err_count", 32'(err_count), 32'(m_err));
      rsp_ready = (h == hold);
      junk_cmd();
      step();
    end
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("post_busy", 32'(busy), 32'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_ctrl"}, 32'({rsp_valid, rsp_err, rsp_timeout, busy, PSEL, PENABLE, PWRITE}), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_paddr"}, 32'(PADDR), 32'd0);
    chk({tag, "_pwdata"}, PWDATA, 32'd0);
    chk({tag, "_pstrb"}, 32'(PSTRB), 32'd0);
    chk({tag, "_counts"}, {txn_count, err_count}, 32'd0);
  endtask

  initial begin
    step();
    step();
    chk_reset_state("reset");
    #2 PRESETn = 1'b1;
    step();

    do_txn(1'b1, 12'h008, 32'hA5A5_0001, 4'hF, 0, 1'b0, 32'h0, 0);
    do_txn(1'b0, 12'h00C, 32'h0, 4'hF, 3, 1'b0, 32'h1234_5678, 0);
    do_txn(1'b0, 12'h0FF, 32'h0, 4'h0, 1, 1'b1, 32'hDEAD_BEEF, 1);
    do_txn(1'b0, 12'h040, 32'h0, 4'h0, -1, 1'b0, 32'h0, 0);
    do_txn(1'b0, 12'h044, 32'h0, 4'h0, TO - 1, 1'b0, 32'hCAFE_0007, 0);
    do_txn(1'b1, 12'h100, 32'h1111_2222, 4'h5, 2, 1'b0, 32'h0, 5);
    do_txn(1'b1, 12'h104, 32'h3333_4444, 4'hA, 0, 1'b0, 32'h0, 0);

    // Asynchronous reset in the middle of an ACCESS phase.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h200; cmd_wdata = 32'h5555_AAAA; cmd_strb = 4'hF;
    step();
    cmd_valid = 1'b0;
    step();
    chk("pre_rst_penable", 32'(PENABLE), 32'd1);
    #2 PRESETn = 1'b0;
    #1;
    chk_reset_state("midrst");
    m_txn = '0;
    m_err = '0;
    @(posedge PCLK);
    #3 PRESETn = 1'b1;
    step();
    do_txn(1'b0, 12'h210, 32'h0, 4'h0, 1, 1'b0, 32'h0BAD_F00D, 0);

    for (int i = 0; i < 40; i++) begin
      do_txn(1'($urandom_range(0, 1)), AW'($urandom), $urandom, 4'($urandom),
             ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, TO - 1)),
             ($urandom_range(0, 3) == 0), $urandom, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
